// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared helpers and default thresholds for the width-converting sync FIFO
package sync_fifo_pkg;

   // almostEmpty default threshold in base words
   localparam int AE_DEFAULT = 2;
   // almostFull default sits this many words below FIFO_DEPTH
   localparam int AF_MARGIN = 2;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // A width multiplier must be a power of two no larger than 8
   function automatic bit mulOk(input int m);
      return (m >= 1) && (m <= 8) && ((1 << clog2(m)) == m);
   endfunction

endpackage

// File: rtl/sync_fifo_wc_if.sv
// sync_fifo_wc_if: producer/consumer bus of the width-converting sync FIFO
interface sync_fifo_wc_if #(
   parameter int DATA_WIDTH        = 8,
   parameter int WR_DATA_WIDTH_MUL = 1,
   parameter int RD_DATA_WIDTH_MUL = 1,
   parameter int ADDRESS_WIDTH     = 4
);
   logic                                    flush;
   logic                                    wrEn;
   logic [WR_DATA_WIDTH_MUL*DATA_WIDTH-1:0] din;
   logic                                    fifoFull;
   logic                                    almostFull;
   logic                                    rdEn;
   logic [RD_DATA_WIDTH_MUL*DATA_WIDTH-1:0] dout;
   logic                                    doutValid;
   logic                                    fifoEmpty;
   logic                                    almostEmpty;
   logic [ADDRESS_WIDTH:0]                  wordCount;
   logic                                    overflow;
   logic                                    underflow;

   modport master (
      output flush, wrEn, din, rdEn,
      input  fifoFull, almostFull, dout, doutValid, fifoEmpty, almostEmpty, wordCount, overflow, underflow
   );

   modport slave (
      input  flush, wrEn, din, rdEn,
      output fifoFull, almostFull, dout, doutValid, fifoEmpty, almostEmpty, wordCount, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: base-word array with multi-word write and read ports, modulo addressing
module sync_fifo_mem #(
   parameter int DATA_WIDTH    = 8,
   parameter int WR_MUL        = 1,
   parameter int RD_MUL        = 1,
   parameter int ADDRESS_WIDTH = 4,
   parameter int FWFT          = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic                         re,
   input  logic [ADDRESS_WIDTH:0]       wrAddr,
   input  logic [ADDRESS_WIDTH:0]       rdAddr,
   input  logic [WR_MUL*DATA_WIDTH-1:0] din,
   output logic [RD_MUL*DATA_WIDTH-1:0] dout
);
   localparam int DEPTH = 1 << ADDRESS_WIDTH;
   localparam int CW = ADDRESS_WIDTH + 1;

   logic [DATA_WIDTH-1:0]        mem [DEPTH];
   logic [RD_MUL*DATA_WIDTH-1:0] rdWord;
   logic [RD_MUL*DATA_WIDTH-1:0] doutQ;

   // Store every base word of an accepted write, wrapping past the end of the array
   always_ff @(posedge clk)
      if (we)
         for (int i = 0; i < WR_MUL; i++)
            mem[ADDRESS_WIDTH'(wrAddr + CW'(i))] <= din[i*DATA_WIDTH +: DATA_WIDTH];

   genvar k;
   for (k = 0; k < RD_MUL; k++) begin : gRd
      assign rdWord[k*DATA_WIDTH +: DATA_WIDTH] = mem[ADDRESS_WIDTH'(rdAddr + CW'(k))];
   end

   // Registered read port: capture the head words on an accepted read, hold otherwise
   always_ff @(posedge clk or posedge rst)
      if (rst) doutQ <= '0;
      else if (re) doutQ <= rdWord;

   assign dout = (FWFT != 0) ? rdWord : doutQ;
endmodule

// File: rtl/sync_fifo_wc.sv
// sync_fifo_wc: single-clock width-converting FIFO with exact count, thresholds, sticky errors and flush
module sync_fifo_wc
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH        = 8,
   parameter int WR_DATA_WIDTH_MUL = 1,
   parameter int RD_DATA_WIDTH_MUL = 1,
   parameter int ADDRESS_WIDTH     = 4,
   parameter int AF_THRESH         = (1 << ADDRESS_WIDTH) - AF_MARGIN,
   parameter int AE_THRESH         = AE_DEFAULT,
   parameter int FWFT              = 0
) (
   input  logic           clk,
   input  logic           rst,
   sync_fifo_wc_if.slave  bus
);
   localparam int DEPTH = 1 << ADDRESS_WIDTH;
   localparam int CW = ADDRESS_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] WR_C = CW'(WR_DATA_WIDTH_MUL);
   localparam logic [CW-1:0] RD_C = CW'(RD_DATA_WIDTH_MUL);
   localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);

   if (!mulOk(WR_DATA_WIDTH_MUL) || !mulOk(RD_DATA_WIDTH_MUL)) begin : gBadMul
      $error("sync_fifo_wc: width multipliers must be 1, 2, 4 or 8");
   end
   if ((DEPTH % WR_DATA_WIDTH_MUL) != 0 || (DEPTH % RD_DATA_WIDTH_MUL) != 0) begin : gBadDepth
      $error("sync_fifo_wc: FIFO depth must be a multiple of both width multipliers");
   end
   if (AF_THRESH > DEPTH) begin : gBadAf
      $error("sync_fifo_wc: AF_THRESH exceeds FIFO depth");
   end

   logic [CW-1:0] wrPtr, rdPtr, count;
   logic          full, empty, wrAcc, rdAcc;
   logic          overflowQ, underflowQ, validQ;

   assign full  = (DEPTH_C - count) < WR_C;
   assign empty = count < RD_C;
   assign wrAcc = bus.wrEn & ~full & ~bus.flush;
   assign rdAcc = bus.rdEn & ~empty & ~bus.flush;

   // Pointers, occupancy and sticky flags; flush wins over any request in the same cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         count      <= '0;
         overflowQ  <= 1'b0;
         underflowQ <= 1'b0;
         validQ     <= 1'b0;
      end else if (bus.flush) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         count      <= '0;
         overflowQ  <= 1'b0;
         underflowQ <= 1'b0;
         validQ     <= 1'b0;
      end else begin
         wrPtr      <= wrPtr + (wrAcc ? WR_C : '0);
         rdPtr      <= rdPtr + (rdAcc ? RD_C : '0);
         count      <= count + (wrAcc ? WR_C : '0) - (rdAcc ? RD_C : '0);
         overflowQ  <= overflowQ | (bus.wrEn & full);
         underflowQ <= underflowQ | (bus.rdEn & empty);
         validQ     <= rdAcc;
      end

   sync_fifo_mem #(
      .DATA_WIDTH    (DATA_WIDTH),
      .WR_MUL        (WR_DATA_WIDTH_MUL),
      .RD_MUL        (RD_DATA_WIDTH_MUL),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .FWFT          (FWFT)
   ) uMem (
      .clk    (clk),
      .rst    (rst),
      .we     (wrAcc),
      .re     (rdAcc),
      .wrAddr (wrPtr),
      .rdAddr (rdPtr),
      .din    (bus.din),
      .dout   (bus.dout)
   );

   assign bus.fifoFull    = full;
   assign bus.fifoEmpty   = empty;
   assign bus.almostFull  = count >= AF_C;
   assign bus.almostEmpty = count <= AE_C;
   assign bus.wordCount   = count;
   assign bus.overflow    = overflowQ;
   assign bus.underflow   = underflowQ;
   assign bus.doutValid   = (FWFT != 0) ? ~empty : validQ;
endmodule

// File: tb/tb_sync_fifo_wc.sv
// tb_sync_fifo_wc: directed checks of the width-converting sync FIFO in four configurations
module tb_sync_fifo_wc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int nChecks = 0;
   int nFails = 0;
   logic [7:0] q[$];
   logic [7:0] expd;
   logic [7:0] w2Exp [4];

   always #5 clk = ~clk;

   sync_fifo_wc_if #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(1), .RD_DATA_WIDTH_MUL(1), .ADDRESS_WIDTH(4)) b0 ();
   sync_fifo_wc_if #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(2), .RD_DATA_WIDTH_MUL(1), .ADDRESS_WIDTH(4)) b1 ();
   sync_fifo_wc_if #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(1), .RD_DATA_WIDTH_MUL(4), .ADDRESS_WIDTH(4)) b2 ();
   sync_fifo_wc_if #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(1), .RD_DATA_WIDTH_MUL(1), .ADDRESS_WIDTH(4)) b3 ();

   sync_fifo_wc #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(1), .RD_DATA_WIDTH_MUL(1), .ADDRESS_WIDTH(4))
      u0 (.clk(clk), .rst(rst), .bus(b0));
   sync_fifo_wc #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(2), .RD_DATA_WIDTH_MUL(1), .ADDRESS_WIDTH(4))
      u1 (.clk(clk), .rst(rst), .bus(b1));
   sync_fifo_wc #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(1), .RD_DATA_WIDTH_MUL(4), .ADDRESS_WIDTH(4))
      u2 (.clk(clk), .rst(rst), .bus(b2));
   sync_fifo_wc #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(1), .RD_DATA_WIDTH_MUL(1), .ADDRESS_WIDTH(4), .FWFT(1))
      u3 (.clk(clk), .rst(rst), .bus(b3));

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      w2Exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      {b0.flush, b0.wrEn, b0.rdEn, b0.din} = '0;
      {b1.flush, b1.wrEn, b1.rdEn, b1.din} = '0;
      {b2.flush, b2.wrEn, b2.rdEn, b2.din} = '0;
      {b3.flush, b3.wrEn, b3.rdEn, b3.din} = '0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      checkEq("rst count", b0.wordCount, 0);
      checkEq("rst flags", {b0.fifoEmpty, b0.fifoFull, b0.almostEmpty, b0.almostFull,
                            b0.doutValid, b0.overflow, b0.underflow}, 7'b1010000);
      checkEq("rst dout", b0.dout, 0);
      checkEq("rst fwft valid", b3.doutValid, 0);

      b0.wrEn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         b0.din = 8'(i);
         tick();
         checkEq("fill count", b0.wordCount, i + 1);
         checkEq("fill full", b0.fifoFull, i == 15);
         checkEq("fill afull", b0.almostFull, i >= 13);
      end
      b0.din = 8'hFF;
      tick();
      b0.wrEn = 1'b0;
      checkEq("ovf set", b0.overflow, 1);
      checkEq("ovf count", b0.wordCount, 16);
      b0.rdEn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         checkEq("rd data", b0.dout, i);
         checkEq("rd valid", b0.doutValid, 1);
      end
      b0.rdEn = 1'b0;
      tick();
      checkEq("rd idle valid", b0.doutValid, 0);
      checkEq("rd idle hold", b0.dout, 8'h0F);
      checkEq("rd empty", b0.fifoEmpty, 1);
      checkEq("rd no udf", b0.underflow, 0);

      b0.wrEn = 1'b1;
      for (int i = 0; i < 7; i++) begin
         b0.din = 8'(48 + i);
         tick();
      end
      checkEq("pre-flush count", b0.wordCount, 7);
      checkEq("pre-flush ovf", b0.overflow, 1);
      b0.flush = 1'b1;
      b0.rdEn = 1'b1;
      tick();
      {b0.flush, b0.wrEn, b0.rdEn} = '0;
      checkEq("flush count", b0.wordCount, 0);
      checkEq("flush empty", b0.fifoEmpty, 1);
      checkEq("flush ovf", b0.overflow, 0);
      checkEq("flush udf", b0.underflow, 0);
      checkEq("flush valid", b0.doutValid, 0);

      b0.wrEn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         b0.din = 8'(32 + i);
         q.push_back(8'(32 + i));
         tick();
      end
      b0.rdEn = 1'b1;
      for (int k = 0; k < 40; k++) begin
         b0.din = 8'(37 + k);
         q.push_back(8'(37 + k));
         expd = q.pop_front();
         tick();
         checkEq("wrap data", b0.dout, expd);
         checkEq("wrap count", b0.wordCount, 5);
      end
      b0.rdEn = 1'b0;
      for (int i = 0; i < 11; i++) begin
         b0.din = 8'(80 + i);
         q.push_back(8'(80 + i));
         tick();
      end
      checkEq("full count", b0.wordCount, 16);
      checkEq("full flag", b0.fifoFull, 1);
      b0.rdEn = 1'b1;
      b0.din = 8'hEE;
      expd = q.pop_front();
      tick();
      {b0.wrEn, b0.rdEn} = '0;
      checkEq("rw full count", b0.wordCount, 15);
      checkEq("rw full data", b0.dout, expd);
      checkEq("rw full ovf", b0.overflow, 1);
      checkEq("rw full valid", b0.doutValid, 1);

      b1.wrEn = 1'b1;
      b1.din = 16'hBBAA;
      tick();
      b1.din = 16'hDDCC;
      tick();
      b1.wrEn = 1'b0;
      checkEq("w2 count", b1.wordCount, 4);
      b1.rdEn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkEq("w2 data", b1.dout, w2Exp[i]);
      end
      b1.rdEn = 1'b0;
      b1.wrEn = 1'b1;
      for (int i = 0; i < 7; i++) begin
         b1.din = 16'(i);
         tick();
      end
      b1.wrEn = 1'b0;
      checkEq("w2 count14", b1.wordCount, 14);
      checkEq("w2 full14", b1.fifoFull, 0);
      checkEq("w2 afull14", b1.almostFull, 1);
      b1.wrEn = 1'b1;
      tick();
      b1.wrEn = 1'b0;
      checkEq("w2 count16", b1.wordCount, 16);
      checkEq("w2 full16", b1.fifoFull, 1);
      b1.rdEn = 1'b1;
      tick();
      b1.rdEn = 1'b0;
      checkEq("w2 count15", b1.wordCount, 15);
      checkEq("w2 full15", b1.fifoFull, 1);
      b1.wrEn = 1'b1;
      tick();
      b1.wrEn = 1'b0;
      checkEq("w2 rej count", b1.wordCount, 15);
      checkEq("w2 rej ovf", b1.overflow, 1);

      b2.wrEn = 1'b1;
      b2.din = 8'h11;
      tick();
      b2.din = 8'h22;
      tick();
      b2.din = 8'h33;
      tick();
      b2.wrEn = 1'b0;
      checkEq("r4 count3", b2.wordCount, 3);
      checkEq("r4 empty3", b2.fifoEmpty, 1);
      b2.rdEn = 1'b1;
      tick();
      b2.rdEn = 1'b0;
      checkEq("r4 udf", b2.underflow, 1);
      checkEq("r4 udf count", b2.wordCount, 3);
      checkEq("r4 udf valid", b2.doutValid, 0);
      b2.wrEn = 1'b1;
      b2.din = 8'h44;
      tick();
      b2.wrEn = 1'b0;
      checkEq("r4 empty4", b2.fifoEmpty, 0);
      b2.rdEn = 1'b1;
      tick();
      b2.rdEn = 1'b0;
      checkEq("r4 data", b2.dout, 32'h44332211);
      checkEq("r4 valid", b2.doutValid, 1);
      checkEq("r4 count0", b2.wordCount, 0);

      b3.wrEn = 1'b1;
      b3.din = 8'h5A;
      tick();
      b3.wrEn = 1'b0;
      checkEq("fwft data", b3.dout, 8'h5A);
      checkEq("fwft valid", b3.doutValid, 1);
      checkEq("fwft nonempty", b3.fifoEmpty, 0);
      tick();
      checkEq("fwft hold", b3.dout, 8'h5A);
      b3.rdEn = 1'b1;
      tick();
      b3.rdEn = 1'b0;
      checkEq("fwft pop empty", b3.fifoEmpty, 1);
      checkEq("fwft pop valid", b3.doutValid, 0);
      checkEq("fwft pop count", b3.wordCount, 0);

      #3;
      rst = 1'b1;
      #1;
      checkEq("arst count", b0.wordCount, 0);
      checkEq("arst ovf", b0.overflow, 0);
      checkEq("arst valid", b0.doutValid, 0);
      checkEq("arst dout", b0.dout, 0);
      checkEq("arst empty", b0.fifoEmpty, 1);
      checkEq("arst w2 count", b1.wordCount, 0);
      checkEq("arst r4 udf", b2.underflow, 0);
      tick();
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule

// File: doc/sync_fifo_wc.md
Name: sync_fifo_wc

Overview:
- Single-clock, parametrised FIFO with independent write and read widths.
- Write and read widths are integer multiples (powers of two) of a base word.
- Adds features the dual-clock FIFO does not have: exact occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, synchronous flush, and a selectable show-ahead (FWFT) read mode.
- Sits between same-clock producer/consumer datapaths that need width conversion and rate smoothing; no gray-code crossing required.

Parameters:
- DATA_WIDTH, 8: base word width in bits.
- WR_DATA_WIDTH_MUL, 1: words per write; 1, 2, 4 or 8.
- RD_DATA_WIDTH_MUL, 1: words per read; 1, 2, 4 or 8.
- ADDRESS_WIDTH, 4: FIFO_DEPTH = 2**ADDRESS_WIDTH base words; FIFO_DEPTH >= max(WR_DATA_WIDTH_MUL, RD_DATA_WIDTH_MUL).
- AF_THRESH, FIFO_DEPTH-2: almostFull asserts when wordCount >= AF_THRESH.
- AE_THRESH, 2: almostEmpty asserts when wordCount <= AE_THRESH.
- FWFT, 0: 0 = registered read (1-cycle latency); 1 = show-ahead (head data visible on dout while not empty).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents and sticky flags.
- wrEn  in  1  write request.
- din  in  WR_DATA_WIDTH_MUL*DATA_WIDTH  write data; word 0 = din[DATA_WIDTH-1:0] is stored first.
- fifoFull  out  1  fewer than WR_DATA_WIDTH_MUL free words.
- almostFull  out  1  see AF_THRESH.
- rdEn  in  1  read request.
- dout  out  RD_DATA_WIDTH_MUL*DATA_WIDTH  read data; oldest word in dout[DATA_WIDTH-1:0].
- doutValid  out  1  dout holds data from an accepted read.
- fifoEmpty  out  1  fewer than RD_DATA_WIDTH_MUL stored words.
- almostEmpty  out  1  see AE_THRESH.
- wordCount  out  ADDRESS_WIDTH+1  stored base words, 0..FIFO_DEPTH.
- overflow  out  1  sticky: a write was attempted while fifoFull.
- underflow  out  1  sticky: a read was attempted while fifoEmpty.

Behaviour:
- State: wrPtr, rdPtr (ADDRESS_WIDTH+1 bits each, wrap naturally mod 2*FIFO_DEPTH) and registered wordCount.
- Flags are combinational from registered state only:
  - fifoFull = (FIFO_DEPTH - wordCount) < WR_DATA_WIDTH_MUL.
  - fifoEmpty = wordCount < RD_DATA_WIDTH_MUL.
  - almostFull and almostEmpty as defined under Parameters.
- Write accept (wrAcc) = wrEn & !fifoFull. On accept, Mem[wrPtr+i] <= word i for i = 0..WR_MUL-1; wrPtr += WR_MUL. Address arithmetic is modulo FIFO_DEPTH, so writes wrap the memory.
- Read accept (rdAcc) = rdEn & !fifoEmpty. On accept, rdPtr += RD_MUL.
- wordCount next = wordCount + (wrAcc ? WR_MUL : 0) - (rdAcc ? RD_MUL : 0).
- Simultaneous read and write:
  - Both are judged against pre-edge state.
  - A write while fifoFull is rejected even if a read is accepted in the same cycle.
  - A read while fifoEmpty is rejected even if a write is accepted in the same cycle.
  - Written data is never readable in the same cycle it is written.
- FWFT=0:
  - On rdAcc, dout <= Mem[rdPtr+i], and doutValid is 1 in the following cycle only.
  - dout holds its value otherwise.
- FWFT=1:
  - dout = Mem[rdPtr+i] combinationally; doutValid = !fifoEmpty.
  - rdEn acts as pop; dout is undefined-but-stable content while empty.
- overflow <= 1 on wrEn & fifoFull; underflow <= 1 on rdEn & fifoEmpty. Both clear only on rst or flush.
- flush:
  - Next cycle: pointers = 0, wordCount = 0, overflow = underflow = doutValid = 0.
  - Any wrEn/rdEn in the flush cycle is ignored and does not set sticky flags.
  - Memory contents are not cleared.
- Reset values:
  - wrPtr = rdPtr = wordCount = 0; dout = 0; doutValid = 0; overflow = underflow = 0.
  - Hence fifoEmpty = 1, fifoFull = 0, almostEmpty = 1 (AE_THRESH >= 0), almostFull = 0 (AF_THRESH > 0).
  - Reset mid-operation discards all content immediately; the memory array has no reset.
- Elaboration-time checks reject:
  - a non-power-of-two MUL;
  - FIFO_DEPTH not a multiple of either MUL;
  - AF_THRESH > FIFO_DEPTH.

Decomposition:
- Package sync_fifo_pkg:
  - MUL legality function (power of two, <= 8);
  - clog2 helper;
  - default threshold constants.
- Sub-module sync_fifo_mem:
  - base-word dual-port array;
  - WR_MUL-word write port and RD_MUL-word read port with modulo addressing;
  - registered or combinational read selected by FWFT.
- Pointers, count, flags and sticky logic stay in the top.

Test Plan:
- Defaults, 16 writes 0x00..0x0F with no reads:
  - fifoFull rises after the 16th accept; almostFull at count 14; wordCount = 16.
  - A 17th write sets overflow, and wordCount stays 16.
  - 16 reads then return 0x00..0x0F, each with doutValid one cycle after rdEn.
- WR_MUL=2, RD_MUL=1:
  - write 0xBBAA then 0xDDCC; reads return AA, BB, CC, DD.
  - fifoFull at wordCount 15 and 16.
- RD_MUL=4, WR_MUL=1:
  - 3 writes leave fifoEmpty = 1; the 4th write clears it.
  - The read returns {w3, w2, w1, w0}.
  - rdEn with 3 words stored sets underflow.
- wordCount = 5, wrEn & rdEn for 40 cycles (pointers wrap twice):
  - wordCount stays 5 and data order is preserved.
  - Simultaneous rd/wr at full (count 16): read accepted, write rejected, count 15, overflow = 1.
- FWFT=1:
  - First write 0x5A: dout = 0x5A and doutValid = 1 the cycle after the write, with no rdEn.
  - rdEn pops it, and fifoEmpty returns to 1.
- Mid-operation at count 7 with overflow set:
  - flush gives count 0, fifoEmpty = 1, overflow = 0 next cycle.
  - An asynchronous rst pulse between clock edges zeroes all outputs immediately, without waiting for clk.
